// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// One operation in flight: accept in IDLE, evaluate in EXEC, hand the result back in RESP.
module alu_arbiter #(
    parameter int WIDTH  = 16,
    parameter int CTRL_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_lt,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_lt,
    input  logic              rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic              last_r;
    logic              id_r;
    logic              grant_valid_s;
    logic              grant_id_s;
    logic [CTRL_W-1:0] sel_ctrl_s;
    logic [WIDTH-1:0]  sel_a_s;
    logic [WIDTH-1:0]  sel_b_s;

    // Grant decision: only in IDLE and never while reset is asserted; ties go to the non-last requester.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (rst_n && (state_r == IDLE)) begin
            if (req0_valid && req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = ~last_r;
            end else if (req0_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b0;
            end else if (req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b1;
            end else begin
                grant_valid_s = 1'b0;
                grant_id_s    = 1'b0;
            end
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // Operand mux toward the ALU registers, steered by the winner.
    always_comb begin
        sel_ctrl_s = {CTRL_W{1'b0}};
        sel_a_s    = {WIDTH{1'b0}};
        sel_b_s    = {WIDTH{1'b0}};
        if (grant_id_s) begin
            sel_ctrl_s = req1_ctrl;
            sel_a_s    = req1_a;
            sel_b_s    = req1_b;
        end else begin
            sel_ctrl_s = req0_ctrl;
            sel_a_s    = req0_a;
            sel_b_s    = req0_b;
        end
    end

    assign req0_ready = grant_valid_s & ~grant_id_s;
    assign req1_ready = grant_valid_s &  grant_id_s;

    // Control FSM with the ALU operand and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            last_r     <= 1'b1;
            id_r       <= 1'b0;
            alu_ctrl   <= {CTRL_W{1'b0}};
            alu_a      <= {WIDTH{1'b0}};
            alu_b      <= {WIDTH{1'b0}};
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= {WIDTH{1'b0}};
            rsp_lt     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        alu_ctrl <= sel_ctrl_s;
                        alu_a    <= sel_a_s;
                        alu_b    <= sel_b_s;
                        id_r     <= grant_id_s;
                        last_r   <= grant_id_s;
                        state_r  <= EXEC;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_lt     <= alu_lt;
                    rsp_id     <= id_r;
                    rsp_valid  <= 1'b1;
                    state_r    <= RESP;
                end
                RESP: begin
                    // rsp_* stay frozen under backpressure; leaving RESP does not also accept.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r   <= RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an adder/compare ALU stub and a response scoreboard.
module tb_alu_arbiter;

    localparam int WIDTH  = 16;
    localparam int CTRL_W = 2;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] result;
        logic             lt;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
    logic [WIDTH-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
    logic              alu_lt;
    logic              rsp_valid, rsp_id, rsp_lt, rsp_ready;
    logic [WIDTH-1:0]  rsp_result;

    int   checks = 0;
    int   errors = 0;
    int   rsp_count = 0;
    exp_t exp_q[$];

    alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_lt(alu_lt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_lt(rsp_lt), .rsp_ready(rsp_ready)
    );

    assign alu_result = alu_a + alu_b;
    assign alu_lt     = (alu_a < alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH-1:0] sum;
        sum      = a + b;
        e.id     = id;
        e.result = sum;
        e.lt     = (a < b);
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on response handshake; reset drops in-flight work.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (req0_valid && req0_ready) exp_q.push_back(model(1'b0, req0_a, req0_b));
            if (req1_valid && req1_ready) exp_q.push_back(model(1'b1, req1_a, req1_b));
            if (rsp_valid && rsp_ready) begin
                rsp_count++;
                chk("sb_nonempty", {31'd0, (exp_q.size() != 0)}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_id", {31'd0, rsp_id}, {31'd0, e.id});
                    chk("sb_result", {16'd0, rsp_result}, {16'd0, e.result});
                    chk("sb_lt", {31'd0, rsp_lt}, {31'd0, e.lt});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_ctrl = 2'd0; req0_a = 16'd0; req0_b = 16'd0;
        req1_valid = 1'b1; req1_ctrl = 2'd0; req1_a = 16'd0; req1_b = 16'd0;

        // Reset state, with both valids high to show readies are gated.
        step(); step();
        chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
        chk("rst_alu_ctrl", {30'd0, alu_ctrl}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
        chk("rst_rsp_lt", {31'd0, rsp_lt}, 32'd0);
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1; rst_n = 1'b1;

        // Single request from req0.
        step();
        req0_valid = 1'b1; req0_a = 16'd10; req0_b = 16'd20; req0_ctrl = 2'b00; #1;
        chk("single_ready0", {31'd0, req0_ready}, 32'd1);
        chk("single_ready1", {31'd0, req1_ready}, 32'd0);
        step(); req0_valid = 1'b0; #1;
        chk("single_alu_a", {16'd0, alu_a}, 32'd10);
        chk("single_alu_b", {16'd0, alu_b}, 32'd20);
        chk("single_exec_ready0", {31'd0, req0_ready}, 32'd0);
        chk("single_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("single_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("single_rsp_result", {16'd0, rsp_result}, 32'd30);
        chk("single_rsp_lt", {31'd0, rsp_lt}, 32'd1);
        step();
        chk("single_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("single_alu_a_hold", {16'd0, alu_a}, 32'd10);

        // Contention right after reset: 0, 1, 0.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 16'd30; req0_b = 16'd5; req0_ctrl = 2'd1;
        req1_valid = 1'b1; req1_a = 16'd7;  req1_b = 16'd9; req1_ctrl = 2'd2; #1;
        chk("cont1_ready0", {31'd0, req0_ready}, 32'd1);
        chk("cont1_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        chk("cont1_alu_a", {16'd0, alu_a}, 32'd30);
        chk("cont1_alu_ctrl", {30'd0, alu_ctrl}, 32'd1);
        chk("cont_exec_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        chk("cont1_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("cont1_rsp_result", {16'd0, rsp_result}, 32'd35);
        chk("cont1_rsp_lt", {31'd0, rsp_lt}, 32'd0);
        step();
        chk("cont2_ready1", {31'd0, req1_ready}, 32'd1);
        chk("cont2_ready0", {31'd0, req0_ready}, 32'd0);
        step();
        chk("cont2_alu_a", {16'd0, alu_a}, 32'd7);
        chk("cont2_alu_ctrl", {30'd0, alu_ctrl}, 32'd2);
        step();
        chk("cont2_rsp_id", {31'd0, rsp_id}, 32'd1);
        chk("cont2_rsp_result", {16'd0, rsp_result}, 32'd16);
        chk("cont2_rsp_lt", {31'd0, rsp_lt}, 32'd1);
        step();
        chk("cont3_ready0", {31'd0, req0_ready}, 32'd1);
        chk("cont3_ready1", {31'd0, req1_ready}, 32'd0);
        step(); req0_valid = 1'b0; req1_valid = 1'b0; #1;
        chk("cont3_alu_a", {16'd0, alu_a}, 32'd30);
        step();
        chk("cont3_rsp_id", {31'd0, rsp_id}, 32'd0);
        step();

        // Backpressure: five cycles of rsp_ready low with req1 waiting.
        req0_valid = 1'b1; req0_a = 16'd100; req0_b = 16'd50; req0_ctrl = 2'd3; #1;
        chk("bp_ready0", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0; rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 16'd3; req1_b = 16'd4; req1_ctrl = 2'd0; #1;
        chk("bp_exec_ready1", {31'd0, req1_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_id", {31'd0, rsp_id}, 32'd0);
            chk("bp_rsp_result", {16'd0, rsp_result}, 32'd150);
            chk("bp_rsp_lt", {31'd0, rsp_lt}, 32'd0);
            chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
            chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
        end
        step(); rsp_ready = 1'b1; #1;
        chk("bp_release_ready1", {31'd0, req1_ready}, 32'd0);
        chk("bp_release_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        step();
        chk("bp_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_idle_ready1", {31'd0, req1_ready}, 32'd1);
        step(); req1_valid = 1'b0; #1;
        chk("bp_req1_alu_a", {16'd0, alu_a}, 32'd3);
        chk("bp_req1_alu_b", {16'd0, alu_b}, 32'd4);
        step();
        chk("bp_req1_rsp_id", {31'd0, rsp_id}, 32'd1);
        chk("bp_req1_rsp_result", {16'd0, rsp_result}, 32'd7);
        step();

        // Wrap-around of the 16-bit sum.
        req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h0002; req1_ctrl = 2'd1; #1;
        chk("wrap_ready1", {31'd0, req1_ready}, 32'd1);
        step(); req1_valid = 1'b0; #1;
        step();
        chk("wrap_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("wrap_rsp_id", {31'd0, rsp_id}, 32'd1);
        chk("wrap_rsp_result", {16'd0, rsp_result}, 32'h0001);
        chk("wrap_rsp_lt", {31'd0, rsp_lt}, 32'd0);
        step();

        // Reset during EXEC discards the operation.
        req0_valid = 1'b1; req0_a = 16'd5; req0_b = 16'd6; req0_ctrl = 2'd2; #1;
        chk("mid_ready0", {31'd0, req0_ready}, 32'd1);
        step(); req0_valid = 1'b0; rst_n = 1'b0; #1;
        chk("mid_exec_alu_a", {16'd0, alu_a}, 32'd5);
        step();
        rst_n = 1'b1;
        req1_valid = 1'b1; req1_a = 16'd9; req1_b = 16'd1; req1_ctrl = 2'd3; #1;
        chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_alu_a", {16'd0, alu_a}, 32'd0);
        chk("mid_alu_b", {16'd0, alu_b}, 32'd0);
        chk("mid_alu_ctrl", {30'd0, alu_ctrl}, 32'd0);
        chk("mid_rsp_result", {16'd0, rsp_result}, 32'd0);
        chk("mid_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("mid_ready1", {31'd0, req1_ready}, 32'd1);
        chk("mid_ready0", {31'd0, req0_ready}, 32'd0);
        step(); req1_valid = 1'b0; #1;
        chk("mid_exec2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_exec2_alu_a", {16'd0, alu_a}, 32'd9);
        step();
        chk("mid_rsp2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("mid_rsp2_id", {31'd0, rsp_id}, 32'd1);
        chk("mid_rsp2_result", {16'd0, rsp_result}, 32'd10);
        step();

        // Idle hold: nothing valid for ten cycles.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_ready0", {31'd0, req0_ready}, 32'd0);
            chk("idle_ready1", {31'd0, req1_ready}, 32'd0);
            chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("idle_alu_a", {16'd0, alu_a}, 32'd9);
            chk("idle_alu_b", {16'd0, alu_b}, 32'd1);
        end

        chk("sb_leftover", exp_q.size(), 32'd0);
        chk("rsp_count", rsp_count, 32'd8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
